// File: rtl/fila_escrita_reg.sv
// fila_escrita_reg: write-back FIFO feeding the register-file write port, with youngest-first bypass lookup
module fila_escrita_reg #(
  parameter int PROFUNDIDADE = 4,
  parameter int LARG_DADO = 32,
  parameter int LARG_END = 6
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            mem_valid,
  input  logic [LARG_END-1:0]             mem_reg,
  input  logic [LARG_DADO-1:0]            mem_dado,
  output logic                            mem_pronto,
  input  logic                            alu_valid,
  input  logic [LARG_END-1:0]             alu_reg,
  input  logic [LARG_DADO-1:0]            alu_dado,
  output logic                            alu_pronto,
  output logic                            reg_write,
  output logic [LARG_END-1:0]             reg_escrita,
  output logic [LARG_DADO-1:0]            escreve_dado,
  input  logic [LARG_END-1:0]             busca_reg1,
  input  logic [LARG_END-1:0]             busca_reg2,
  output logic                            hit1,
  output logic                            hit2,
  output logic [LARG_DADO-1:0]            dado_byp1,
  output logic [LARG_DADO-1:0]            dado_byp2,
  output logic [$clog2(PROFUNDIDADE):0]   ocupacao,
  output logic                            erro_estouro
);
  localparam int PW = $clog2(PROFUNDIDADE);
  logic [LARG_END-1:0] fila_reg [PROFUNDIDADE];
  logic [LARG_DADO-1:0] fila_dado [PROFUNDIDADE];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] livres;
  logic push_mem, push_alu, pop;
  assign livres = (PW+1)'(PROFUNDIDADE) - ocupacao;
  assign mem_pronto = (livres >= (PW+1)'(1)) & ~reset;
  assign alu_pronto = (livres >= (mem_valid ? (PW+1)'(2) : (PW+1)'(1))) & ~reset;
  assign push_mem = mem_valid & mem_pronto;
  assign push_alu = alu_valid & alu_pronto;
  assign pop = ocupacao != '0;
  // mem goes first because it belongs to the older instruction
  always_ff @(posedge clock) begin
    if (push_mem) begin
      fila_reg[wr_ptr] <= mem_reg;
      fila_dado[wr_ptr] <= mem_dado;
    end
    if (push_alu) begin
      fila_reg[wr_ptr + PW'(push_mem)] <= alu_reg;
      fila_dado[wr_ptr + PW'(push_mem)] <= alu_dado;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ocupacao <= '0;
      reg_write <= 1'b0;
      reg_escrita <= '0;
      escreve_dado <= '0;
      erro_estouro <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push_mem) + PW'(push_alu);
      rd_ptr <= rd_ptr + PW'(pop);
      ocupacao <= ocupacao + (PW+1)'(push_mem) + (PW+1)'(push_alu) - (PW+1)'(pop);
      reg_write <= pop;
      if (pop) begin
        reg_escrita <= fila_reg[rd_ptr];
        escreve_dado <= fila_dado[rd_ptr];
      end
      if ((mem_valid & ~mem_pronto) | (alu_valid & ~alu_pronto)) erro_estouro <= 1'b1;
    end
  end
  // later matches overwrite earlier ones, so the tail (youngest) wins
  function automatic logic [LARG_DADO:0] busca(input logic [LARG_END-1:0] a);
    logic [LARG_DADO:0] r;
    logic [PW-1:0] idx;
    r = (reg_write && reg_escrita == a) ? {1'b1, escreve_dado} : '0;
    for (int i = 0; i < PROFUNDIDADE; i++) begin
      idx = rd_ptr + PW'(i);
      if ((PW+1)'(i) < ocupacao && fila_reg[idx] == a) r = {1'b1, fila_dado[idx]};
    end
    return r;
  endfunction
  always_comb {hit1, dado_byp1} = busca(busca_reg1);
  always_comb {hit2, dado_byp2} = busca(busca_reg2);
endmodule

// File: tb/tb_fila_escrita_reg.sv
// tb_fila_escrita_reg: directed checks of queueing, drain order, overflow, bypass and reset
module tb_fila_escrita_reg;
  logic clock = 1'b0;
  logic reset;
  logic mem_valid, alu_valid;
  logic [5:0] mem_reg, alu_reg, busca_reg1, busca_reg2;
  logic [31:0] mem_dado, alu_dado;
  logic mem_pronto, alu_pronto, reg_write, hit1, hit2, erro_estouro;
  logic [5:0] reg_escrita;
  logic [31:0] escreve_dado, dado_byp1, dado_byp2;
  logic [2:0] ocupacao;
  logic [31:0] rf [64];
  int n_chk = 0;
  int n_fail = 0;
  int wcount = 0;
  int snap;

  fila_escrita_reg dut (
    .clock(clock), .reset(reset),
    .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_dado(mem_dado), .mem_pronto(mem_pronto),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_dado(alu_dado), .alu_pronto(alu_pronto),
    .reg_write(reg_write), .reg_escrita(reg_escrita), .escreve_dado(escreve_dado),
    .busca_reg1(busca_reg1), .busca_reg2(busca_reg2), .hit1(hit1), .hit2(hit2),
    .dado_byp1(dado_byp1), .dado_byp2(dado_byp2), .ocupacao(ocupacao), .erro_estouro(erro_estouro)
  );

  always #5 clock = ~clock;

  // register-file model: samples on the negedge inside the write window
  always @(negedge clock) if (reg_write) begin
    rf[reg_escrita] = escreve_dado;
    wcount++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr_chk(input string tag, input logic [5:0] r, input logic [31:0] d);
    chk({tag, "_we"}, 64'(reg_write), 64'd1);
    chk({tag, "_reg"}, 64'(reg_escrita), 64'(r));
    chk({tag, "_dado"}, 64'(escreve_dado), 64'(d));
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rf[i] = 32'hDEAD_0000;
    reset = 1; mem_valid = 0; alu_valid = 0; mem_reg = 0; alu_reg = 0;
    mem_dado = 0; alu_dado = 0; busca_reg1 = 0; busca_reg2 = 0;
    #2;
    chk("pronto_in_reset", 64'(mem_pronto), 64'd0);
    tick(); tick();
    reset = 0; #1;
    chk("rst_ocup", 64'(ocupacao), 64'd0);
    chk("rst_we", 64'(reg_write), 64'd0);
    chk("rst_reg", 64'(reg_escrita), 64'd0);
    chk("rst_dado", 64'(escreve_dado), 64'd0);
    chk("rst_erro", 64'(erro_estouro), 64'd0);
    chk("rst_mem_pronto", 64'(mem_pronto), 64'd1);
    // 1: single mem entry
    mem_valid = 1; mem_reg = 5; mem_dado = 32'hA5;
    tick(); mem_valid = 0;
    chk("t1_ocup", 64'(ocupacao), 64'd1);
    chk("t1_we0", 64'(reg_write), 64'd0);
    tick();
    wr_chk("t1", 5, 32'hA5);
    chk("t1_ocup0", 64'(ocupacao), 64'd0);
    tick();
    chk("t1_we_off", 64'(reg_write), 64'd0);
    chk("t1_reg_hold", 64'(reg_escrita), 64'd5);
    chk("t1_rf5", 64'(rf[5]), 64'hA5);
    // 2: simultaneous mem and alu
    mem_valid = 1; mem_reg = 3; mem_dado = 32'h11;
    alu_valid = 1; alu_reg = 4; alu_dado = 32'h22; #1;
    chk("t2_mp", 64'(mem_pronto), 64'd1);
    chk("t2_ap", 64'(alu_pronto), 64'd1);
    tick(); mem_valid = 0; alu_valid = 0;
    chk("t2_ocup2", 64'(ocupacao), 64'd2);
    tick();
    wr_chk("t2a", 3, 32'h11);
    chk("t2_ocup1", 64'(ocupacao), 64'd1);
    tick();
    wr_chk("t2b", 4, 32'h22);
    tick();
    chk("t2_we_off", 64'(reg_write), 64'd0);
    // 3: saturation and overflow
    mem_valid = 1; mem_reg = 10; mem_dado = 32'h100;
    alu_valid = 1; alu_reg = 11; alu_dado = 32'h200;
    tick();
    chk("t3_ocup_a", 64'(ocupacao), 64'd2);
    mem_dado = 32'h101; alu_dado = 32'h201; #1;
    chk("t3_ap_a", 64'(alu_pronto), 64'd1);
    tick();
    chk("t3_ocup_b", 64'(ocupacao), 64'd3);
    wr_chk("t3_w0", 10, 32'h100);
    mem_dado = 32'h102; alu_dado = 32'h202; #1;
    chk("t3_ap_drop", 64'(alu_pronto), 64'd0);
    chk("t3_mp_keep", 64'(mem_pronto), 64'd1);
    chk("t3_erro_pre", 64'(erro_estouro), 64'd0);
    tick(); mem_valid = 0; alu_valid = 0;
    chk("t3_erro_set", 64'(erro_estouro), 64'd1);
    chk("t3_ocup_c", 64'(ocupacao), 64'd3);
    wr_chk("t3_w1", 11, 32'h200);
    tick(); wr_chk("t3_w2", 10, 32'h101);
    tick(); wr_chk("t3_w3", 11, 32'h201);
    tick(); wr_chk("t3_w4", 10, 32'h102);
    tick();
    chk("t3_we_off", 64'(reg_write), 64'd0);
    chk("t3_erro_sticky", 64'(erro_estouro), 64'd1);
    reset = 1; tick(); reset = 0; #1;
    chk("t3_erro_clr", 64'(erro_estouro), 64'd0);
    // 4: bypass priority
    busca_reg1 = 7; busca_reg2 = 8;
    mem_valid = 1; mem_reg = 7; mem_dado = 32'h1;
    tick();
    chk("t4_hit_fifo", 64'(hit1), 64'd1);
    chk("t4_byp_fifo", 64'(dado_byp1), 64'd1);
    mem_dado = 32'h2;
    tick(); mem_valid = 0;
    chk("t4_hit1", 64'(hit1), 64'd1);
    chk("t4_byp1_young", 64'(dado_byp1), 64'd2);
    chk("t4_hit2_miss", 64'(hit2), 64'd0);
    chk("t4_byp2_zero", 64'(dado_byp2), 64'd0);
    tick();
    chk("t4_hit_outreg", 64'(hit1), 64'd1);
    chk("t4_byp_outreg", 64'(dado_byp1), 64'd2);
    tick();
    chk("t4_hit_gone", 64'(hit1), 64'd0);
    chk("t4_byp_gone", 64'(dado_byp1), 64'd0);
    chk("t4_rf7", 64'(rf[7]), 64'd2);
    busca_reg2 = 9;
    mem_valid = 1; mem_reg = 9; mem_dado = 32'hAA;
    alu_valid = 1; alu_reg = 9; alu_dado = 32'hBB;
    #1;
    chk("t4_same_cycle_not_searched", 64'(hit2), 64'd0);
    tick(); mem_valid = 0; alu_valid = 0;
    chk("t4_dup_byp", 64'(dado_byp2), 64'hBB);
    tick(); chk("t4_dup_byp2", 64'(dado_byp2), 64'hBB);
    tick(); tick();
    chk("t4_rf9", 64'(rf[9]), 64'hBB);
    // 5: reset mid-drain
    mem_valid = 1; mem_reg = 20; mem_dado = 32'h20;
    alu_valid = 1; alu_reg = 21; alu_dado = 32'h21;
    tick();
    mem_reg = 22; mem_dado = 32'h22; alu_reg = 23; alu_dado = 32'h23;
    tick(); mem_valid = 0; alu_valid = 0;
    chk("t5_ocup3", 64'(ocupacao), 64'd3);
    reset = 1; tick(); reset = 0;
    chk("t5_ocup0", 64'(ocupacao), 64'd0);
    chk("t5_we0", 64'(reg_write), 64'd0);
    snap = wcount;
    tick(); tick(); tick();
    chk("t5_no_writes", 64'(wcount - snap), 64'd0);
    chk("t5_rf21", 64'(rf[21]), 64'hDEAD_0000);
    // 6: ten back-to-back entries with pointer wrap
    for (int i = 0; i < 10; i++) begin
      mem_valid = 1; mem_reg = 6'(30 + i); mem_dado = 32'h1000 + i;
      tick();
      if (i > 0) begin
        wr_chk("t6", 6'(30 + i - 1), 32'h1000 + i - 1);
        chk("t6_ocup", 64'(ocupacao), 64'd1);
      end
    end
    mem_valid = 0;
    tick(); wr_chk("t6_last", 39, 32'h1009);
    tick(); chk("t6_we_off", 64'(reg_write), 64'd0);
    chk("t6_rf35", 64'(rf[35]), 64'h1005);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
